// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART constants and FSM state encoding (TX and RX paths).
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int FRAME_BITS      = 10;
    localparam int DATA_BITS       = 8;
    localparam int DEFAULT_CLK_DIV = 1600;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t IDLE  = 2'd0;
    localparam uart_state_t START = 2'd1;
    localparam uart_state_t DATA  = 2'd2;
    localparam uart_state_t STOP  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with circular pointers, occupancy counter and
//            sticky overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_LVL_W = $clog2(DEPTH + 1);
    localparam logic [C_LVL_W-1:0] C_LVL_FULL = C_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_LVL_W-1:0] r_level;
    logic [C_LVL_W-1:0] w_level_next;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;
    logic               w_do_wr;
    logic               w_do_rd;

    // Full is judged before any same-cycle pop, so a write while full is
    // always dropped even if a slot frees up on the same edge.
    assign w_do_wr = wr_en && !r_full;
    assign w_do_rd = rd_en && !r_empty;

    always_comb begin
        w_level_next = r_level;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_level_next = r_level + C_LVL_W'(1);
            2'b01:   w_level_next = r_level - C_LVL_W'(1);
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            r_level <= w_level_next;
            r_full  <= (w_level_next == C_LVL_FULL);
            r_empty <= (w_level_next == '0);
        end
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : FIFO-buffered 8N1 UART transmitter with clock-enable baud timing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [7:0]                        wr_data,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              overflow,
    output logic                              busy,
    output logic                              TX
);

    localparam int                 C_CNT_W    = $clog2(CLK_DIV);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]         C_LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t               r_state;
    logic [C_CNT_W-1:0]        r_baud_cnt;
    logic [2:0]                r_bit_idx;
    logic [DATA_BITS-1:0]      r_shift;
    logic                      r_tx;
    logic                      r_busy;
    logic                      w_tick;
    logic                      w_pop;
    logic [7:0]                w_head;

    assign w_tick = (r_baud_cnt == C_CNT_MAX);
    // Popping on the final stop cycle lets the next start bit follow with no gap.
    assign w_pop  = !empty && ((r_state == IDLE) || (r_state == STOP && w_tick));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (w_pop),
        .rd_data  (w_head),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_shift    <= w_head;
                        r_bit_idx  <= '0;
                        r_baud_cnt <= '0;
                        r_state    <= START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_baud_cnt <= '0;
                        r_state    <= DATA;
                        r_tx       <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + C_CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == C_LAST_BIT) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + C_CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift   <= w_head;
                            r_bit_idx <= '0;
                            r_state   <= START;
                            r_tx      <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + C_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign TX   = r_tx;
    assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
// Module   : tb_uart_tx_buffered
// Brief    : Directed self-checking bench for uart_tx_buffered (CLK_DIV=4, depth 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_buffered;

    localparam int CLK_DIV   = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 10 * CLK_DIV;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       overflow;
    logic       busy;
    logic       TX;

    int checks = 0;
    int errors = 0;

    uart_tx_buffered #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .busy     (busy),
        .TX       (TX)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level at sample i (0..FRAME_LEN-1) of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        int j;
        j = i / CLK_DIV;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Samples consecutive frames from frame-sample index start_i; optionally
    // pushes inj_data at sample inj_idx and checks level around that push.
    task automatic run_frames(input logic [39:0] bytes, input int nframes, input int start_i,
                              input int inj_idx, input logic [7:0] inj_data,
                              input logic [2:0] inj_level);
        for (int i = start_i; i < nframes * FRAME_LEN; i++) begin
            @(negedge clk);
            chk($sformatf("frame_tx[%0d]", i), TX, exp_bit(bytes[8*(i/FRAME_LEN) +: 8], i % FRAME_LEN));
            chk($sformatf("frame_busy[%0d]", i), busy, 1'b1);
            if (i == inj_idx || i == inj_idx + 1)
                chk($sformatf("inj_level[%0d]", i), level, inj_level);
            if (i == inj_idx) begin
                wr_en   = 1'b1;
                wr_data = inj_data;
            end else begin
                wr_en = 1'b0;
            end
        end
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_tx", TX, 1'b1);
            chk("idle_busy", busy, 1'b0);
        end
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", TX, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;

        // Idle with no writes
        idle_chk(100);

        // Single byte 0xA5
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        chk("t1_level", level, 3'd1);
        chk("t1_empty", empty, 1'b0);
        chk("t1_tx_pre", TX, 1'b1);
        chk("t1_busy_pre", busy, 1'b0);
        wr_en = 1'b0;
        run_frames({32'h0, 8'hA5}, 1, 0, -1, 8'h00, 3'd0);
        @(negedge clk);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_tx_end", TX, 1'b1);
        chk("t1_empty_end", empty, 1'b1);

        // Three back-to-back frames
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h00;
        @(negedge clk);
        chk("t2_level_a", level, 3'd1);
        wr_data = 8'hFF;
        @(negedge clk);
        chk("t2_level_b", level, 3'd1);
        chk("t2_tx_start", TX, 1'b0);
        wr_data = 8'h3C;
        @(negedge clk);
        chk("t2_level_c", level, 3'd2);
        chk("t2_tx_start2", TX, 1'b0);
        wr_en = 1'b0;
        run_frames({16'h0, 8'h3C, 8'hFF, 8'h00}, 3, 2, -1, 8'h00, 3'd0);
        @(negedge clk);
        chk("t2_busy_end", busy, 1'b0);
        chk("t2_tx_end", TX, 1'b1);
        chk("t2_level_end", level, 3'd0);

        // Six writes: one popped, four buffered, sixth dropped
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("t3_full", full, 1'b1);
                chk("t3_level_full", level, 3'd4);
                chk("t3_ovf_pre", overflow, 1'b0);
            end
            wr_en   = 1'b1;
            wr_data = 8'(8'h11 * (k + 1));
        end
        @(negedge clk);
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_full_hold", full, 1'b1);
        chk("t3_level_hold", level, 3'd4);
        wr_en = 1'b0;
        run_frames({8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 5, 5, -1, 8'h00, 3'd0);
        @(negedge clk);
        chk("t3_busy_end", busy, 1'b0);
        chk("t3_ovf_sticky", overflow, 1'b1);
        chk("t3_level_end", level, 3'd0);
        idle_chk(20);

        // Simultaneous write and pop at level 2
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h5A;
        @(negedge clk);
        wr_data = 8'hC3;
        @(negedge clk);
        chk("t4_tx_start", TX, 1'b0);
        chk("t4_level_a", level, 3'd1);
        wr_data = 8'h0F;
        run_frames({8'h0, 8'hE7, 8'h0F, 8'hC3, 8'h5A}, 4, 1, FRAME_LEN - 1, 8'hE7, 3'd2);
        @(negedge clk);
        chk("t4_busy_end", busy, 1'b0);
        chk("t4_level_end", level, 3'd0);

        // Reset mid-DATA with two bytes queued
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h81;
        @(negedge clk);
        wr_data = 8'h3C;
        @(negedge clk);
        chk("t5_tx_start", TX, 1'b0);
        wr_data = 8'h7E;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            chk($sformatf("t5_tx[%0d]", i), TX, exp_bit(8'h81, i));
            if (i == 10) begin
                chk("t5_level_q", level, 3'd2);
                rst_n = 1'b0;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_tx", TX, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_level", level, 3'd0);
        chk("t5_empty", empty, 1'b1);
        chk("t5_full", full, 1'b0);
        chk("t5_ovf", overflow, 1'b0);
        idle_chk(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
